gauss_sample_collector: RTL and testbench

//  Downstream stage of the multihat Gaussian generator.
//  - Captures each 16-bit sample presented with out_V_ap_vld into a FIFO.
//  - Drains the FIFO through a valid/ready stream.
//  - In parallel, accumulates windowed moments (count, sum, sum of squares) for on-line distribution checks.

---
 rtl/gauss_sample_collector.sv | 170 +++++++++++++++++
 tb/tb_gauss_sample_collector.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/gauss_sample_collector.sv
// Sample collector behind the multihat Gaussian generator: buffers strobed samples
// in a FIFO drained by a valid/ready stream and accumulates windowed moments.
module gauss_sample_collector #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 16,
  parameter int CNT_W  = 16
) (
  input  logic                        ap_clk,
  input  logic                        ap_rst_n,
  input  logic [DATA_W-1:0]           in_data,
  input  logic                        in_vld,
  output logic [DATA_W-1:0]           m_data,
  output logic                        m_valid,
  input  logic                        m_ready,
  output logic [$clog2(DEPTH):0]      fifo_level,
  output logic                        overflow,
  input  logic                        clear,
  input  logic                        start,
  input  logic [CNT_W-1:0]            win_len,
  output logic [CNT_W-1:0]            stats_cnt,
  output logic [DATA_W+CNT_W-1:0]     stats_sum,
  output logic [2*DATA_W+CNT_W-1:0]   stats_sumsq,
  output logic                        stats_busy,
  output logic                        stats_done
);

  localparam int AW    = $clog2(DEPTH);
  localparam int PW    = AW + 1;
  localparam int SUM_W = DATA_W + CNT_W;
  localparam int SQ_W  = 2*DATA_W + CNT_W;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DONE    = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // FIFO
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic              overflow_q, overflow_d;
  logic              empty, full, push, pop;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  // Stream handshake: a word moves on every cycle where m_valid and m_ready are
  // both high; m_valid never depends on m_ready and, once raised, stays high with
  // m_data stable until that transfer happens (clear/reset excepted).
  assign m_valid    = ~empty;
  assign pop        = m_valid & m_ready;
  assign push       = in_vld & (~full | pop) & ~clear;
  assign m_data     = m_valid ? mem_q[rd_ptr_q[AW-1:0]] : '0;
  assign fifo_level = wr_ptr_q - rd_ptr_q;
  assign overflow   = overflow_q;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    overflow_d = overflow_q;
    if (clear) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      overflow_d = 1'b0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      if (in_vld && full && !pop) overflow_d = 1'b1;
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage needs no reset: m_data is masked to zero whenever the FIFO is empty.
  always_ff @(posedge ap_clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= in_data;
  end

  // ---------------------------------------------------------------------------
  // Windowed statistics
  // ---------------------------------------------------------------------------
  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        len_q, len_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d, cnt_inc;
  logic [SUM_W-1:0]        sum_q, sum_d;
  logic [SQ_W-1:0]         sumsq_q, sumsq_d;
  logic signed [2*DATA_W-1:0] samp_ext, samp_sq;
  logic                    start_ok;

  assign start_ok = start & (win_len != '0);
  assign cnt_inc  = cnt_q + CNT_W'(1);
  assign samp_ext = {{DATA_W{in_data[DATA_W-1]}}, in_data};
  // Low 2*DATA_W bits of the widened product are the exact (non-negative) square.
  assign samp_sq  = samp_ext * samp_ext;

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q <= IDLE;
      len_q   <= '0;
      cnt_q   <= '0;
      sum_q   <= '0;
      sumsq_q <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      sumsq_q <= sumsq_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (start_ok) state_d = COLLECT;
        COLLECT: if (in_vld && (cnt_inc == len_q)) state_d = DONE;
        DONE:    if (start_ok) state_d = COLLECT;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    len_d   = len_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    sumsq_d = sumsq_q;
    if (clear) begin
      len_d   = '0;
      cnt_d   = '0;
      sum_d   = '0;
      sumsq_d = '0;
    end else if (start_ok && (state_q != COLLECT)) begin
      len_d   = win_len;
      cnt_d   = '0;
      sum_d   = '0;
      sumsq_d = '0;
    end else if ((state_q == COLLECT) && in_vld) begin
      cnt_d   = cnt_inc;
      sum_d   = sum_q + {{CNT_W{in_data[DATA_W-1]}}, in_data};
      sumsq_d = sumsq_q + {{CNT_W{1'b0}}, samp_sq};
    end
  end

  always_comb begin
    stats_busy  = (state_q == COLLECT);
    stats_done  = (state_q == DONE);
    stats_cnt   = cnt_q;
    stats_sum   = sum_q;
    stats_sumsq = sumsq_q;
  end

endmodule

// File: tb/tb_gauss_sample_collector.sv
// Bench for gauss_sample_collector: directed scenarios plus random traffic, with a
// FIFO scoreboard drained by a stream monitor and a list-based moments model.
module tb_gauss_sample_collector;

  localparam int DATA_W = 16;
  localparam int DEPTH  = 16;
  localparam int CNT_W  = 16;

  logic                      ap_clk;
  logic                      ap_rst_n;
  logic [DATA_W-1:0]         in_data;
  logic                      in_vld;
  logic [DATA_W-1:0]         m_data;
  logic                      m_valid;
  logic                      m_ready;
  logic [$clog2(DEPTH):0]    fifo_level;
  logic                      overflow;
  logic                      clear;
  logic                      start;
  logic [CNT_W-1:0]          win_len;
  logic [CNT_W-1:0]          stats_cnt;
  logic [DATA_W+CNT_W-1:0]   stats_sum;
  logic [2*DATA_W+CNT_W-1:0] stats_sumsq;
  logic                      stats_busy;
  logic                      stats_done;

  gauss_sample_collector #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .in_data(in_data), .in_vld(in_vld),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .fifo_level(fifo_level),
    .overflow(overflow), .clear(clear), .start(start), .win_len(win_len),
    .stats_cnt(stats_cnt), .stats_sum(stats_sum), .stats_sumsq(stats_sumsq),
    .stats_busy(stats_busy), .stats_done(stats_done)
  );

  // ---------------- clock / reset ----------------
  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, actual=running required=finished");
    $fatal(1, "watchdog");
  end

  // ---------------- counters ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [DATA_W-1:0] exp_q[$];   // scoreboard: words the stream must still deliver
  logic [DATA_W-1:0] mdl_q[$];   // FIFO contents as seen after the last edge
  bit                mdl_ovf;
  int                mdl_mode;   // 0 idle, 1 collecting, 2 done
  int                mdl_target;
  int                win_samp[$];

  function automatic longint win_sum();
    longint s = 0;
    foreach (win_samp[i]) s += win_samp[i];
    return s;
  endfunction

  function automatic longint win_sumsq();
    longint s = 0;
    foreach (win_samp[i]) s += longint'(win_samp[i]) * longint'(win_samp[i]);
    return s;
  endfunction

  task automatic model_reset();
    exp_q.delete();
    mdl_q.delete();
    win_samp.delete();
    mdl_ovf    = 0;
    mdl_mode   = 0;
    mdl_target = 0;
  endtask

  // Applies the currently driven inputs to the model, as one rising edge.
  task automatic model_edge();
    bit do_pop, do_push;
    if (clear) begin
      exp_q.delete();
      mdl_q.delete();
      mdl_ovf = 0;
      mdl_mode = 0;
      win_samp.delete();
      return;
    end
    do_pop  = m_ready && (mdl_q.size() > 0);
    do_push = in_vld && ((mdl_q.size() < DEPTH) || do_pop);
    if (do_pop) void'(mdl_q.pop_front());
    if (do_push) begin
      mdl_q.push_back(in_data);
      exp_q.push_back(in_data);
    end
    if (in_vld && !do_push) mdl_ovf = 1;
    if (start && win_len != 0 && mdl_mode != 1) begin
      mdl_mode   = 1;
      mdl_target = int'(win_len);
      win_samp.delete();
    end else if (mdl_mode == 1 && in_vld) begin
      win_samp.push_back(int'($signed(in_data)));
      if (win_samp.size() == mdl_target) mdl_mode = 2;
    end
  endtask

  task automatic check_outputs();
    chk("fifo_level", longint'(fifo_level), longint'(mdl_q.size()));
    chk("m_valid", longint'(m_valid), longint'(mdl_q.size() > 0));
    if (mdl_q.size() > 0) chk("m_data_head", longint'(m_data), longint'(mdl_q[0]));
    chk("overflow", longint'(overflow), longint'(mdl_ovf));
    chk("stats_busy", longint'(stats_busy), longint'(mdl_mode == 1));
    chk("stats_done", longint'(stats_done), longint'(mdl_mode == 2));
    chk("stats_cnt", longint'(stats_cnt), longint'(win_samp.size()));
    chk("stats_sum", longint'($signed(stats_sum)), win_sum());
    chk("stats_sumsq", longint'(stats_sumsq), win_sumsq());
  endtask

  // ---------------- driver ----------------
  task automatic step(input bit v, input logic [DATA_W-1:0] d, input bit r,
                      input bit c, input bit s, input logic [CNT_W-1:0] wl);
    in_vld = v; in_data = d; m_ready = r; clear = c; start = s; win_len = wl;
    @(posedge ap_clk);
    model_edge();
    #1;
    check_outputs();
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_m_valid"}, longint'(m_valid), 0);
    chk({tag, "_m_data"}, longint'(m_data), 0);
    chk({tag, "_level"}, longint'(fifo_level), 0);
    chk({tag, "_overflow"}, longint'(overflow), 0);
    chk({tag, "_cnt"}, longint'(stats_cnt), 0);
    chk({tag, "_sum"}, longint'(stats_sum), 0);
    chk({tag, "_sumsq"}, longint'(stats_sumsq), 0);
    chk({tag, "_busy"}, longint'(stats_busy), 0);
    chk({tag, "_done"}, longint'(stats_done), 0);
  endtask

  // ---------------- stream monitor ----------------
  always @(negedge ap_clk) begin
    if (ap_rst_n && m_valid && m_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL stream_unexpected: actual=%0h required=no_word", m_data);
      end else begin
        chk("stream_data", longint'(m_data), longint'(exp_q.pop_front()));
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    in_vld = 0; in_data = '0; m_ready = 0; clear = 0; start = 0; win_len = '0;
    model_reset();
    ap_rst_n = 0;
    #12;
    check_all_zero("reset");
    @(negedge ap_clk);
    ap_rst_n = 1;

    // 1: single sample appears one cycle later
    step(1, 16'h0005, 0, 0, 0, 0);
    chk("t1_data", longint'(m_data), 5);
    chk("t1_level", longint'(fifo_level), 1);

    // 2: overfill, then clear
    step(0, 0, 0, 1, 0, 0);
    for (int i = 1; i <= 17; i++) step(1, 16'(i), 0, 0, 0, 0);
    chk("t2_level", longint'(fifo_level), 16);
    chk("t2_overflow", longint'(overflow), 1);
    chk("t2_head", longint'(m_data), 1);
    step(0, 0, 0, 1, 0, 0);
    chk("t2_clr_level", longint'(fifo_level), 0);
    chk("t2_clr_overflow", longint'(overflow), 0);

    // 3: push and pop together while full
    for (int i = 0; i < 16; i++) step(1, 16'(16'h100 + i), 0, 0, 0, 0);
    step(1, 16'h0099, 1, 0, 0, 0);
    chk("t3_level", longint'(fifo_level), 16);
    chk("t3_overflow", longint'(overflow), 0);
    for (int i = 0; i < 17; i++) step(0, 0, 1, 0, 0, 0);

    // 4: window of four known samples
    step(0, 0, 1, 0, 1, 16'd4);
    step(1, 16'h0003, 1, 0, 0, 0);
    step(1, 16'hFFFE, 1, 0, 0, 0);
    step(1, 16'h0005, 1, 0, 0, 0);
    step(1, 16'hFFFF, 1, 0, 0, 0);
    chk("t4_done", longint'(stats_done), 1);
    chk("t4_cnt", longint'(stats_cnt), 4);
    chk("t4_sum", longint'($signed(stats_sum)), 5);
    chk("t4_sumsq", longint'(stats_sumsq), 39);
    step(1, 16'h7FFF, 1, 0, 0, 0);
    chk("t4_frozen_cnt", longint'(stats_cnt), 4);
    chk("t4_frozen_sum", longint'($signed(stats_sum)), 5);

    // 5: start during collect is ignored; clear beats start
    step(0, 0, 1, 0, 1, 16'd4);
    step(1, 16'h8000, 1, 0, 0, 0);
    step(1, 16'h0010, 1, 0, 0, 0);
    step(0, 0, 1, 0, 1, 16'd9);
    step(1, 16'h0020, 1, 0, 0, 0);
    chk("t5_busy", longint'(stats_busy), 1);
    step(1, 16'h0030, 1, 0, 0, 0);
    chk("t5_cnt", longint'(stats_cnt), 4);
    chk("t5_done", longint'(stats_done), 1);
    step(1, 16'h0001, 1, 1, 1, 16'd3);
    chk("t5_clr_busy", longint'(stats_busy), 0);
    chk("t5_clr_cnt", longint'(stats_cnt), 0);
    step(1, 16'h0002, 1, 0, 1, 16'd0);
    chk("t5_zero_len_busy", longint'(stats_busy), 0);

    // 6: asynchronous reset mid-window with data buffered
    step(0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 1, 16'd10);
    for (int i = 0; i < 5; i++) step(1, 16'($urandom_range(0, 65535)), 0, 0, 0, 0);
    chk("t6_level", longint'(fifo_level), 5);
    ap_rst_n = 0;
    model_reset();
    #1;
    check_all_zero("t6_rst");
    @(negedge ap_clk);
    @(negedge ap_clk);
    ap_rst_n = 1;
    step(0, 0, 0, 0, 0, 0);
    chk("t6_post_level", longint'(fifo_level), 0);

    // random traffic
    for (int n = 0; n < 600; n++) begin
      bit v, r, c, s;
      logic [CNT_W-1:0] wl;
      v  = ($urandom_range(0, 99) < 60);
      r  = ($urandom_range(0, 99) < 45);
      c  = ($urandom_range(0, 99) < 2);
      s  = ($urandom_range(0, 99) < 8);
      wl = ($urandom_range(0, 9) == 0) ? '0 : CNT_W'($urandom_range(1, 12));
      step(v, DATA_W'($urandom), r, c, s, wl);
    end

    for (int i = 0; i < DEPTH + 2; i++) step(0, 0, 1, 0, 0, 0);
    chk("final_scoreboard_empty", longint'(exp_q.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
